// File: rtl/apb_arb_pkg.sv
// Shared arbitration types and helpers for the APB master grant scheduler and its interconnect.
package apb_arb_pkg;

    localparam int unsigned ARB_FIXED = 1;
    localparam int unsigned ARB_RR    = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Binary index of a one-hot vector of up to 32 masters; 0 for an all-zero input.
    function automatic int unsigned onehot_to_bin(input logic [31:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational one-hot pick: aged requesters first, then fixed priority or round-robin from ptr.
module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int unsigned NO_OF_MASTERS   = 4,
    parameter int unsigned MASTER_ID_WIDTH = 2,
    parameter int unsigned ARB_TYPE        = ARB_RR
) (
    input  logic [NO_OF_MASTERS-1:0]   req,
    input  logic [NO_OF_MASTERS-1:0]   aged,
    input  logic [MASTER_ID_WIDTH-1:0] ptr,
    output logic [NO_OF_MASTERS-1:0]   pick_c
);

    localparam bit RR_MODE = (ARB_TYPE == ARB_RR);

    logic [NO_OF_MASTERS-1:0] aged_req;
    logic [NO_OF_MASTERS-1:0] upper_mask;
    logic [NO_OF_MASTERS-1:0] upper_req;
    logic [NO_OF_MASTERS-1:0] pool;

    // Round-robin without a rotator: requesters at/above ptr win, else wrap to the lowest one.
    always_comb begin
        aged_req   = req & aged;
        upper_mask = '0;
        for (int unsigned i = 0; i < NO_OF_MASTERS; i++) begin
            upper_mask[i] = (MASTER_ID_WIDTH'(i) >= ptr);
        end
        upper_req = req & upper_mask;

        if (|aged_req) begin
            pool = aged_req;
        end else if (RR_MODE && (|upper_req)) begin
            pool = upper_req;
        end else begin
            pool = req;
        end

        pick_c = pool & (~pool + NO_OF_MASTERS'(1));
    end

endmodule

// File: rtl/apb_master_grant_scheduler.sv
// Registered APB bus arbiter: one-hot grant with aging, bounded locking and a per-transfer watchdog.
module apb_master_grant_scheduler
    import apb_arb_pkg::*;
#(
    parameter int unsigned NO_OF_MASTERS    = 4,
    parameter int unsigned MASTER_ID_WIDTH  = 2,
    parameter int unsigned ARBITRATION_TYPE = 2,
    parameter int unsigned AGE_LIMIT        = 8,
    parameter int unsigned LOCK_MAX         = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 64
) (
    input  logic                       I_PCLK,
    input  logic                       I_PRESETN,
    input  logic [NO_OF_MASTERS-1:0]   I_REQ,
    input  logic [NO_OF_MASTERS-1:0]   I_LOCK,
    input  logic                       I_XFER_DONE,
    output logic [NO_OF_MASTERS-1:0]   O_GRANT,
    output logic [MASTER_ID_WIDTH-1:0] O_GRANT_IDX,
    output logic                       O_GRANT_VLD,
    output logic                       O_TIMEOUT,
    output logic [MASTER_ID_WIDTH-1:0] O_TIMEOUT_IDX
);

    localparam int unsigned N       = NO_OF_MASTERS;
    localparam int unsigned W       = MASTER_ID_WIDTH;
    localparam int unsigned AGE_W   = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
    localparam int unsigned LOCK_W  = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int unsigned LOCK_LAST = (LOCK_MAX > 0) ? LOCK_MAX - 1 : 0;
    localparam bit          WD_ON   = (TIMEOUT_CYCLES != 0);
    localparam bit          AGE_ON  = (AGE_LIMIT != 0);

    arb_state_e        state_q, state_d;
    logic [N-1:0]      grant_d;
    logic [W-1:0]      grant_idx_d;
    logic              grant_vld_d;
    logic              timeout_d;
    logic [W-1:0]      timeout_idx_d;
    logic [W-1:0]      ptr_q, ptr_d;
    logic [AGE_W-1:0]  age_q [N];
    logic [AGE_W-1:0]  age_d [N];
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

    logic [N-1:0]      aged;
    logic [N-1:0]      cand;
    logic [N-1:0]      pick;
    logic [W-1:0]      pick_idx;
    logic              owner_req;
    logic              owner_lock;
    logic              wd_expire;
    logic              lock_hold;
    logic              tenure_end;
    logic              pick_en;

    // Tenure decisions; O_GRANT doubles as the owner mask.
    always_comb begin
        owner_req  = |(I_REQ & O_GRANT);
        owner_lock = |(I_LOCK & O_GRANT);
        wd_expire  = WD_ON && (state_q == OWN) && !I_XFER_DONE && (wd_cnt_q == WD_W'(WD_LAST));
        lock_hold  = (state_q == OWN) && I_XFER_DONE && owner_lock && owner_req &&
                     (lock_cnt_q < LOCK_W'(LOCK_LAST));
        tenure_end = (state_q == OWN) && (I_XFER_DONE || wd_expire) && !lock_hold;
        pick_en    = (|I_REQ) && ((state_q == IDLE) || tenure_end);

        // The outgoing owner only competes when nobody else is asking.
        cand = I_REQ;
        if ((state_q == OWN) && (|(I_REQ & ~O_GRANT))) begin
            cand = I_REQ & ~O_GRANT;
        end

        aged = '0;
        for (int unsigned i = 0; i < N; i++) begin
            aged[i] = AGE_ON && (age_q[i] == AGE_W'(AGE_LIMIT));
        end
    end

    apb_rr_picker #(
        .NO_OF_MASTERS  (N),
        .MASTER_ID_WIDTH(W),
        .ARB_TYPE       (ARBITRATION_TYPE)
    ) u_picker (
        .req   (cand),
        .aged  (aged),
        .ptr   (ptr_q),
        .pick_c(pick)
    );

    assign pick_idx = W'(onehot_to_bin(32'(pick)));

    // Next state, grant, pointer and counters.
    always_comb begin
        state_d       = state_q;
        grant_d       = O_GRANT;
        grant_idx_d   = O_GRANT_IDX;
        grant_vld_d   = O_GRANT_VLD;
        ptr_d         = ptr_q;
        lock_cnt_d    = lock_cnt_q;
        wd_cnt_d      = '0;
        timeout_d     = wd_expire;
        timeout_idx_d = wd_expire ? O_GRANT_IDX : O_TIMEOUT_IDX;

        if (pick_en) begin
            state_d     = OWN;
            grant_d     = pick;
            grant_idx_d = pick_idx;
            grant_vld_d = 1'b1;
            ptr_d       = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
            lock_cnt_d  = '0;
        end else if (tenure_end) begin
            state_d     = IDLE;
            grant_d     = '0;
            grant_idx_d = '0;
            grant_vld_d = 1'b0;
            lock_cnt_d  = '0;
        end else if (lock_hold) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end else if ((state_q == OWN) && WD_ON) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end

        for (int unsigned i = 0; i < N; i++) begin
            age_d[i] = age_q[i];
            if (!I_REQ[i] || (pick_en && pick[i])) begin
                age_d[i] = '0;
            end else if (pick_en && (age_q[i] != AGE_W'(AGE_LIMIT))) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge I_PCLK or negedge I_PRESETN) begin
        if (!I_PRESETN) begin
            state_q       <= IDLE;
            O_GRANT       <= '0;
            O_GRANT_IDX   <= '0;
            O_GRANT_VLD   <= 1'b0;
            O_TIMEOUT     <= 1'b0;
            O_TIMEOUT_IDX <= '0;
            ptr_q         <= '0;
            lock_cnt_q    <= '0;
            wd_cnt_q      <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            O_GRANT       <= grant_d;
            O_GRANT_IDX   <= grant_idx_d;
            O_GRANT_VLD   <= grant_vld_d;
            O_TIMEOUT     <= timeout_d;
            O_TIMEOUT_IDX <= timeout_idx_d;
            ptr_q         <= ptr_d;
            lock_cnt_q    <= lock_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            for (int unsigned i = 0; i < N; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_apb_master_grant_scheduler.sv
// Bench for apb_master_grant_scheduler: round-robin and fixed-priority instances share stimulus,
// each checked every cycle against a rule-level model plus hand-computed spot values.
module tb_apb_master_grant_scheduler;

    localparam int N     = 4;
    localparam int AGE   = 3;
    localparam int LOCKM = 2;
    localparam int TO    = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic       done;

    logic [3:0] grant [2];
    logic [1:0] gidx  [2];
    logic       gvld  [2];
    logic       tout  [2];
    logic [1:0] tidx  [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: 0 = round-robin, 1 = fixed priority.
    int m_own   [2];
    int m_owner [2];
    int m_ptr   [2];
    int m_age   [2][4];
    int m_lock  [2];
    int m_wd    [2];
    int m_to    [2];
    int m_toi   [2];

    always #5 clk = ~clk;

    apb_master_grant_scheduler #(
        .NO_OF_MASTERS(N), .MASTER_ID_WIDTH(2), .ARBITRATION_TYPE(2),
        .AGE_LIMIT(AGE), .LOCK_MAX(LOCKM), .TIMEOUT_CYCLES(TO)
    ) u_rr (
        .I_PCLK(clk), .I_PRESETN(rst_n), .I_REQ(req), .I_LOCK(lock), .I_XFER_DONE(done),
        .O_GRANT(grant[0]), .O_GRANT_IDX(gidx[0]), .O_GRANT_VLD(gvld[0]),
        .O_TIMEOUT(tout[0]), .O_TIMEOUT_IDX(tidx[0])
    );

    apb_master_grant_scheduler #(
        .NO_OF_MASTERS(N), .MASTER_ID_WIDTH(2), .ARBITRATION_TYPE(1),
        .AGE_LIMIT(AGE), .LOCK_MAX(LOCKM), .TIMEOUT_CYCLES(TO)
    ) u_fp (
        .I_PCLK(clk), .I_PRESETN(rst_n), .I_REQ(req), .I_LOCK(lock), .I_XFER_DONE(done),
        .O_GRANT(grant[1]), .O_GRANT_IDX(gidx[1]), .O_GRANT_VLD(gvld[1]),
        .O_TIMEOUT(tout[1]), .O_TIMEOUT_IDX(tidx[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Winner among requesters (outgoing owner excluded unless alone): aged first, then policy.
    function automatic int model_pick(input int k, input int excl);
        logic [3:0] c;
        int j;
        c = req;
        if (excl >= 0) begin
            c[excl] = 1'b0;
            if (c == 4'b0000) c = req;
        end
        for (int i = 0; i < N; i++) if (c[i] && m_age[k][i] == AGE) return i;
        if (k == 1) begin
            for (int i = 0; i < N; i++) if (c[i]) return i;
        end
        for (int s = 0; s < N; s++) begin
            j = (m_ptr[k] + s) % N;
            if (c[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_step(input int k);
        int  p;
        int  o;
        bit  ev;
        bit  expire;
        ev = 0;
        p  = 0;
        o  = m_owner[k];
        m_to[k] = 0;
        if (m_own[k] == 0) begin
            if (req != 4'b0000) begin
                p  = model_pick(k, -1);
                ev = 1;
            end
        end else begin
            expire = !done && (m_wd[k] == TO - 1);
            if (expire) begin
                m_to[k]  = 1;
                m_toi[k] = o;
            end
            if (done && lock[o] && req[o] && m_lock[k] < LOCKM - 1) begin
                m_lock[k]++;
                m_wd[k] = 0;
            end else if (done || expire) begin
                if (req != 4'b0000) begin
                    p  = model_pick(k, o);
                    ev = 1;
                end else begin
                    m_own[k]  = 0;
                    m_lock[k] = 0;
                    m_wd[k]   = 0;
                end
            end else begin
                m_wd[k]++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!req[i]) m_age[k][i] = 0;
            else if (ev) m_age[k][i] = (i == p) ? 0 : ((m_age[k][i] < AGE) ? m_age[k][i] + 1 : AGE);
        end
        if (ev) begin
            m_own[k]   = 1;
            m_owner[k] = p;
            m_ptr[k]   = (p + 1) % N;
            m_lock[k]  = 0;
            m_wd[k]    = 0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_lock[k] = 0;
            m_wd[k] = 0; m_to[k] = 0; m_toi[k] = 0;
            for (int i = 0; i < N; i++) m_age[k][i] = 0;
        end
    endtask

    function automatic logic [9:0] model_out(input int k);
        logic [3:0] g;
        logic [1:0] gi;
        g  = (m_own[k] != 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
        gi = (m_own[k] != 0) ? 2'(m_owner[k]) : 2'b00;
        return {g, gi, 1'(m_own[k]), 1'(m_to[k]), 2'(m_toi[k])};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // Every-cycle comparison of all outputs of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check((k == 0) ? "cycle_rr" : "cycle_fp",
                  32'({grant[k], gidx[k], gvld[k], tout[k], tidx[k]}), 32'(model_out(k)));
        end
    end

    task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic d);
        req  = r;
        lock = l;
        done = d;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL time_limit: bench still running at %0t, expected to finish", $time);
        $fatal(1);
    end

    initial begin
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        int exp_fp [5] = '{0, 1, 0, 2, 3};
        rst_n = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        done  = 1'b0;
        #1;
        check("reset_grant_rr", 32'(grant[0]), 32'd0);
        check("reset_vld_fp",   32'(gvld[1]),  32'd0);
        check("reset_tout_rr",  32'(tout[0]),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // All four requesting, done every second cycle: RR rotates, fixed priority ages master 2/3 in.
        cyc(4'b1111, 4'b0000, 1'b0);
        check("t1_rr_first", 32'(gidx[0]), 32'(exp_rr[0]));
        check("t1_fp_first", 32'(gidx[1]), 32'(exp_fp[0]));
        for (int j = 1; j < 5; j++) begin
            cyc(4'b1111, 4'b0000, 1'b0);
            check("t1_rr_held", 32'(gvld[0]), 32'd1);
            cyc(4'b1111, 4'b0000, 1'b1);
            check("t1_rr_idx", 32'(gidx[0]), 32'(exp_rr[j]));
            check("t1_fp_idx", 32'(gidx[1]), 32'(exp_fp[j]));
        end
        cyc(4'b0000, 4'b0000, 1'b1);
        check("t1_idle_rr", 32'(gvld[0]), 32'd0);

        // Master 2 locks: two transfers back to back, then master 0.
        cyc(4'b0101, 4'b0100, 1'b0);
        check("t3_rr_m2", 32'(gidx[0]), 32'd2);
        cyc(4'b0101, 4'b0100, 1'b1);
        check("t3_rr_locked", 32'(gidx[0]), 32'd2);
        cyc(4'b0101, 4'b0100, 1'b1);
        check("t3_rr_m0", 32'(gidx[0]), 32'd0);
        check("t3_fp_locked", 32'(gidx[1]), 32'd2);
        cyc(4'b0000, 4'b0000, 1'b1);
        check("t3_idle_fp", 32'(gvld[1]), 32'd0);

        // Master 1 never completes (and drops its request): timeout after 8 owned cycles.
        cyc(4'b0010, 4'b0000, 1'b0);
        check("t4_rr_m1", 32'(gidx[0]), 32'd1);
        for (int w = 0; w < 7; w++) cyc(4'b0000, 4'b0000, 1'b0);
        check("t4_still_owned", 32'(grant[0]), 32'b0010);
        check("t4_no_early_to", 32'(tout[0]), 32'd0);
        cyc(4'b0000, 4'b0000, 1'b0);
        check("t4_timeout", 32'(tout[0]), 32'd1);
        check("t4_timeout_idx", 32'(tidx[0]), 32'd1);
        check("t4_released", 32'(gvld[0]), 32'd0);
        cyc(4'b0000, 4'b0000, 1'b0);
        check("t4_pulse_ends", 32'(tout[0]), 32'd0);
        check("t4_idx_held", 32'(tidx[1]), 32'd1);

        // Done arrives on the expiry edge: no timeout, normal hand-over.
        cyc(4'b1001, 4'b0000, 1'b0);
        check("t5_rr_m3", 32'(gidx[0]), 32'd3);
        check("t5_fp_m0", 32'(gidx[1]), 32'd0);
        for (int w = 0; w < 7; w++) cyc(4'b1001, 4'b0000, 1'b0);
        cyc(4'b1001, 4'b0000, 1'b1);
        check("t5_no_timeout", 32'(tout[0]), 32'd0);
        check("t5_rr_m0", 32'(gidx[0]), 32'd0);
        check("t5_fp_m3", 32'(gidx[1]), 32'd3);

        // Asynchronous reset in the middle of a tenure.
        cyc(4'b1001, 4'b0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_clear_rr", 32'(grant[0]), 32'd0);
        check("t6_async_clear_fp", 32'(grant[1]), 32'd0);
        @(negedge clk);
        req   = 4'b1000;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rr_m3", 32'(gidx[0]), 32'd3);
        check("t6_to_idx_reset", 32'(tidx[0]), 32'd0);
        cyc(4'b1111, 4'b0000, 1'b1);
        check("t6_rr_wrap_m0", 32'(gidx[0]), 32'd0);
        cyc(4'b0000, 4'b0000, 1'b1);

        // Mixed traffic, model-checked every cycle.
        for (int c = 0; c < 300; c++) begin
            cyc(4'($urandom), 4'($urandom), ($urandom_range(0, 2) == 0));
        end
        cyc(4'b0000, 4'b0000, 1'b1);
        for (int c = 0; c < 10; c++) cyc(4'b0000, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
